// File: rtl/vga_pkg.sv
// Shared VGA constants and the delayed-bus bundle used by the draw chain.
// Sprite defaults here are what draw_ball uses unless overridden at instantiation.
package vga_pkg;

    localparam int HOR_PIXELS = 1024;
    localparam int VER_PIXELS = 768;

    localparam int BALL_W = 32;
    localparam int BALL_H = 32;

    localparam int          RGB_W        = 12;
    localparam logic [11:0] TRANSP_COLOR = 12'hF0F;

    // Timing signals that travel together through each draw stage.
    typedef struct packed {
        logic [10:0] vcount;
        logic        vsync;
        logic        vblnk;
        logic [10:0] hcount;
        logic        hsync;
        logic        hblnk;
    } vga_bus_t;

endpackage

// File: rtl/delay.sv
// Generic shift-register delay line: dout is din delayed by CLK_DEL clock cycles.
// Every stage is cleared by the synchronous active-low reset.
module delay #(
    parameter int WIDTH   = 1,
    parameter int CLK_DEL = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stages [CLK_DEL];

    // NOTE: every stage is reset (not just the last) so a mid-frame reset
    // flushes all in-flight pixels instead of leaking them out afterwards.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < CLK_DEL; i++) begin
                stages[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments make every stage sample the
            // previous stage's old value, giving a true shift register.
            stages[0] <= din;
            for (int i = 1; i < CLK_DEL; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign dout = stages[CLK_DEL-1];

endmodule

// File: rtl/draw_ball.sv
// Ball sprite overlay: turns hcount/vcount into ball ROM addresses and mixes the
// ROM pixels over the background, keeping the VGA bus aligned (3 clk latency).
module draw_ball
    import vga_pkg::*;
#(
    parameter int                    BALL_W       = vga_pkg::BALL_W,
    parameter int                    BALL_H       = vga_pkg::BALL_H,
    parameter int                    ADDR_WIDTH   = 20,
    parameter int                    DATA_WIDTH   = 12,
    parameter logic [DATA_WIDTH-1:0] TRANSP_COLOR = vga_pkg::TRANSP_COLOR
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [11:0]           xpos,
    input  logic [11:0]           ypos,
    input  logic [10:0]           vcount_in,
    input  logic                  vsync_in,
    input  logic                  vblnk_in,
    input  logic [10:0]           hcount_in,
    input  logic                  hsync_in,
    input  logic                  hblnk_in,
    input  logic [DATA_WIDTH-1:0] rgb_in,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic [10:0]           vcount_out,
    output logic                  vsync_out,
    output logic                  vblnk_out,
    output logic [10:0]           hcount_out,
    output logic                  hsync_out,
    output logic                  hblnk_out,
    output logic [DATA_WIDTH-1:0] rgb_out
);

    // Position is latched once per frame so the ball never tears.
    logic [11:0] xpos_q;
    logic [11:0] ypos_q;
    logic        vblnk_prev;
    logic        vblnk_rise;

    assign vblnk_rise = vblnk_in && !vblnk_prev;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            xpos_q     <= xpos;
            ypos_q     <= ypos;
            vblnk_prev <= 1'b0;
        end else begin
            vblnk_prev <= vblnk_in;
            if (vblnk_rise) begin
                xpos_q <= xpos;
                ypos_q <= ypos;
            end
        end
    end

    // Window test and sprite-local address; 13 bits keeps xpos+BALL_W from wrapping.
    logic [12:0]           h_ext;
    logic [12:0]           v_ext;
    logic [12:0]           x_ext;
    logic [12:0]           y_ext;
    logic [12:0]           dx;
    logic [12:0]           dy;
    logic                  in_win;
    logic [ADDR_WIDTH-1:0] win_addr;

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        h_ext    = {2'b00, hcount_in};
        v_ext    = {2'b00, vcount_in};
        x_ext    = {1'b0, xpos_q};
        y_ext    = {1'b0, ypos_q};
        dx       = h_ext - x_ext;
        dy       = v_ext - y_ext;
        in_win   = (h_ext >= x_ext) && (h_ext < x_ext + 13'(BALL_W))
                && (v_ext >= y_ext) && (v_ext < y_ext + 13'(BALL_H))
                && !hblnk_in && !vblnk_in;
        win_addr = ADDR_WIDTH'(32'(dy) * 32'(BALL_W) + 32'(dx));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rom_addr <= '0;
        end else begin
            rom_addr <= in_win ? win_addr : '0;
        end
    end

    // Alignment: VGA bus needs 3 stages, rgb_in and in_win 2 (the mux adds the 3rd).
    vga_bus_t              bus_in;
    vga_bus_t              bus_d3;
    logic [DATA_WIDTH-1:0] rgb_in_d2;
    logic                  in_win_d2;

    assign bus_in = '{vcount: vcount_in, vsync: vsync_in, vblnk: vblnk_in,
                      hcount: hcount_in, hsync: hsync_in, hblnk: hblnk_in};

    delay #(
        .WIDTH   ($bits(vga_bus_t)),
        .CLK_DEL (3)
    ) u_bus_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (bus_in),
        .dout  (bus_d3)
    );

    delay #(
        .WIDTH   (DATA_WIDTH),
        .CLK_DEL (2)
    ) u_rgb_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (rgb_in),
        .dout  (rgb_in_d2)
    );

    delay #(
        .WIDTH   (1),
        .CLK_DEL (2)
    ) u_win_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (in_win),
        .dout  (in_win_d2)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rgb_out <= '0;
        end else begin
            rgb_out <= (in_win_d2 && rom_data != TRANSP_COLOR) ? rom_data : rgb_in_d2;
        end
    end

    assign vcount_out = bus_d3.vcount;
    assign vsync_out  = bus_d3.vsync;
    assign vblnk_out  = bus_d3.vblnk;
    assign hcount_out = bus_d3.hcount;
    assign hsync_out  = bus_d3.hsync;
    assign hblnk_out  = bus_d3.hblnk;

endmodule

// File: tb/tb_draw_ball.sv
// Self-checking bench for draw_ball: directed sprite cases plus a random VGA
// stream compared every cycle against a history-based reference model.
module tb_draw_ball;
    import vga_pkg::*;

    localparam int AW   = 20;
    localparam int DW   = 12;
    localparam int MAXC = 12000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [11:0]   xpos, ypos;
    logic [10:0]   vcount_in, hcount_in;
    logic          vsync_in, vblnk_in, hsync_in, hblnk_in;
    logic [DW-1:0] rgb_in;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data = '0;
    logic [10:0]   vcount_out, hcount_out;
    logic          vsync_out, vblnk_out, hsync_out, hblnk_out;
    logic [DW-1:0] rgb_out;

    always #5 clk = ~clk;

    draw_ball dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .xpos       (xpos),
        .ypos       (ypos),
        .vcount_in  (vcount_in),
        .vsync_in   (vsync_in),
        .vblnk_in   (vblnk_in),
        .hcount_in  (hcount_in),
        .hsync_in   (hsync_in),
        .hblnk_in   (hblnk_in),
        .rgb_in     (rgb_in),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .vcount_out (vcount_out),
        .vsync_out  (vsync_out),
        .vblnk_out  (vblnk_out),
        .hcount_out (hcount_out),
        .hsync_out  (hsync_out),
        .hblnk_out  (hblnk_out),
        .rgb_out    (rgb_out)
    );

    // Ball ROM model: synchronous read, rom[i] = i except one key-colour pixel.
    logic [DW-1:0] rom [1024];
    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = DW'(i);
        rom[5] = TRANSP_COLOR;
    end
    always @(posedge clk) rom_data <= (rom_addr < 1024) ? rom[rom_addr[9:0]] : '0;

    // Reference model: per-cycle input history and the ball position seen in each cycle.
    typedef struct {
        bit        rn;
        bit [11:0] x, y;
        bit [10:0] h, v;
        bit        hs, vs, hb, vb;
        bit [11:0] rgb;
    } in_t;

    in_t       hist [MAXC];
    bit [11:0] px [MAXC+1];
    bit [11:0] py [MAXC+1];
    bit        prev_vb = 1'b0;
    int        cyc    = 0;
    int        checks = 0;
    int        errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic bit ref_hit(input in_t s, input bit [11:0] x, input bit [11:0] y);
        int h = int'(s.h);
        int v = int'(s.v);
        return !s.hb && !s.vb && h >= int'(x) && h < int'(x) + BALL_W
                             && v >= int'(y) && v < int'(y) + BALL_H;
    endfunction

    function automatic int ref_addr(input in_t s, input bit [11:0] x, input bit [11:0] y);
        return (int'(s.v) - int'(y)) * BALL_W + (int'(s.h) - int'(x));
    endfunction

    // Expected outputs in cycle c follow from the inputs of cycle c-3 (c-1 for rom_addr),
    // and are zero whenever any reset edge lies on that path.
    task automatic compare(input int c);
        in_t       s;
        bit        ok3;
        int        a;
        bit [11:0] exp_rgb;
        if (c < 3) return;
        s   = hist[c-3];
        ok3 = hist[c-1].rn && hist[c-2].rn && hist[c-3].rn;
        chk("vcount_out", 32'(vcount_out), ok3 ? 32'(s.v)  : 0);
        chk("hcount_out", 32'(hcount_out), ok3 ? 32'(s.h)  : 0);
        chk("vsync_out",  32'(vsync_out),  ok3 ? 32'(s.vs) : 0);
        chk("hsync_out",  32'(hsync_out),  ok3 ? 32'(s.hs) : 0);
        chk("vblnk_out",  32'(vblnk_out),  ok3 ? 32'(s.vb) : 0);
        chk("hblnk_out",  32'(hblnk_out),  ok3 ? 32'(s.hb) : 0);
        exp_rgb = s.rgb;
        if (ref_hit(s, px[c-3], py[c-3])) begin
            a = ref_addr(s, px[c-3], py[c-3]);
            if (rom[a] != TRANSP_COLOR) exp_rgb = rom[a];
        end
        chk("rgb_out", 32'(rgb_out), ok3 ? 32'(exp_rgb) : 0);
        a = 0;
        if (hist[c-1].rn && ref_hit(hist[c-1], px[c-1], py[c-1]))
            a = ref_addr(hist[c-1], px[c-1], py[c-1]);
        chk("rom_addr", 32'(rom_addr), 32'(a));
    endtask

    // One clock: record inputs, advance the position model at the edge, check at negedge.
    task automatic tick();
        hist[cyc] = '{rn: rst_n, x: xpos, y: ypos, h: hcount_in, v: vcount_in,
                      hs: hsync_in, vs: vsync_in, hb: hblnk_in, vb: vblnk_in, rgb: rgb_in};
        @(posedge clk);
        px[cyc+1] = px[cyc];
        py[cyc+1] = py[cyc];
        if (!hist[cyc].rn) begin
            px[cyc+1] = hist[cyc].x;
            py[cyc+1] = hist[cyc].y;
            prev_vb   = 1'b0;
        end else begin
            if (hist[cyc].vb && !prev_vb) begin
                px[cyc+1] = hist[cyc].x;
                py[cyc+1] = hist[cyc].y;
            end
            prev_vb = hist[cyc].vb;
        end
        @(negedge clk);
        cyc++;
        compare(cyc);
    endtask

    task automatic vblnk_pulse();
        vblnk_in = 1'b0;
        tick();
        vblnk_in = 1'b1;
        tick();
        vblnk_in = 1'b0;
        tick();
    endtask

    // Hold one visible pixel for three clocks; rom_addr checked at N+1, rgb_out at N+3.
    task automatic pixel(input int h, input int v, input logic [11:0] rgb,
                         input int exp_addr, input logic [11:0] exp_rgb);
        hcount_in = 11'(h);
        vcount_in = 11'(v);
        hblnk_in  = 1'b0;
        vblnk_in  = 1'b0;
        rgb_in    = rgb;
        tick();
        chk("dir_rom_addr", 32'(rom_addr), 32'(exp_addr));
        tick();
        tick();
        chk("dir_rgb_out", 32'(rgb_out), 32'(exp_rgb));
    endtask

    initial begin
        px[0] = '0;
        py[0] = '0;

        // Reset with random inputs.
        rst_n     = 1'b0;
        xpos      = 12'($urandom);
        ypos      = 12'($urandom);
        for (int i = 0; i < 3; i++) begin
            vcount_in = 11'($urandom);
            hcount_in = 11'($urandom);
            {vsync_in, vblnk_in, hsync_in, hblnk_in} = 4'($urandom);
            rgb_in    = 12'($urandom);
            tick();
        end
        chk("rst_rgb_out", 32'(rgb_out), 0);
        chk("rst_hcount_out", 32'(hcount_out), 0);
        chk("rst_rom_addr", 32'(rom_addr), 0);
        rst_n = 1'b1;

        // Latch the ball at (100,50) and probe its corners.
        xpos = 12'd100;
        ypos = 12'd50;
        hsync_in = 1'b0;
        vsync_in = 1'b0;
        vblnk_pulse();
        pixel(100, 50, 12'h123, 0,    12'h000);
        pixel(131, 81, 12'h456, 1023, 12'h3FF);
        pixel(132, 81, 12'h789, 0,    12'h789);
        pixel(105, 50, 12'h0A0, 5,    12'h0A0);
        pixel(99,  50, 12'h0B0, 0,    12'h0B0);

        // Mid-frame position change is ignored until the next vblnk rise.
        xpos = 12'd300;
        pixel(100, 50, 12'h111, 0, 12'h000);
        pixel(300, 50, 12'h111, 0, 12'h111);
        vblnk_pulse();
        pixel(300, 50, 12'h111, 0, 12'h000);
        pixel(100, 50, 12'h222, 0, 12'h222);

        // Right-edge clipping: no wrap to column 0.
        xpos = 12'd1010;
        vblnk_pulse();
        pixel(1010, 50, 12'h333, 0,  12'h000);
        pixel(1023, 50, 12'h333, 13, 12'h00D);
        pixel(0,    50, 12'h333, 0,  12'h333);

        // Random VGA stream biased around the sprite, with occasional resets.
        xpos = 12'd100;
        ypos = 12'd50;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 99) < 70) begin
                hcount_in = 11'(90 + $urandom_range(0, 60));
                vcount_in = 11'(40 + $urandom_range(0, 60));
            end else begin
                hcount_in = 11'($urandom);
                vcount_in = 11'($urandom);
            end
            hsync_in = 1'($urandom);
            vsync_in = 1'($urandom);
            hblnk_in = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 99) < 4) vblnk_in = ~vblnk_in;
            if ($urandom_range(0, 99) < 3) begin
                xpos = 12'(80 + $urandom_range(0, 50));
                ypos = 12'(30 + $urandom_range(0, 50));
            end else if ($urandom_range(0, 999) < 5) begin
                xpos = 12'(4064 + $urandom_range(0, 31));
            end
            rgb_in = 12'($urandom);
            rst_n  = ($urandom_range(0, 499) != 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
